draw_clock_digits: RTL and testbench

//  Overlay stage directly downstream of the 800x600@60 VGA timing generator (40 MHz pclk).

---
 rtl/vga_pkg.sv | 39 +++
 rtl/font_rom.sv | 46 ++++
 rtl/draw_clock_digits.sv | 136 +++++++++++++
 tb/tb_draw_clock_digits.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_pkg: 800x600@60 timing constants, glyph codes and shared types
// Rev 1.0
// ----------------------------------------------------------------------------
package vga_pkg;

  localparam int c_h_active     = 800;
  localparam int c_h_total      = 1056;
  localparam int c_h_sync_start = 840;
  localparam int c_h_sync_end   = 967;
  localparam int c_v_active     = 600;
  localparam int c_v_total      = 628;
  localparam int c_v_sync_start = 601;
  localparam int c_v_sync_end   = 604;
  localparam int c_rgb_w        = 12;
  localparam int c_glyph_w      = 8;
  localparam int c_glyph_h      = 16;

  typedef logic [3:0] glyph_t;

  localparam glyph_t GLYPH_COLON = 4'd10;
  localparam glyph_t GLYPH_BLANK = 4'd15;

  typedef struct packed {
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
  } vga_timing_t;

  function automatic glyph_t bcd_to_glyph(input logic [3:0] bcd);
    return (bcd > 4'd9) ? GLYPH_BLANK : glyph_t'(bcd);
  endfunction

endpackage
`default_nettype wire

// File: rtl/font_rom.sv
`default_nettype none
// ----------------------------------------------------------------------------
// font_rom: 256x8 glyph ROM, address {code,row}, one-cycle registered read
// Rev 1.0
// ----------------------------------------------------------------------------
module font_rom
  import vga_pkg::*;
(
  input  logic                 clk,
  input  logic [7:0]           i_addr,
  output logic [c_glyph_w-1:0] o_data
);

  logic [127:0]          w_bits;
  logic [6:0]            w_shift;
  logic [c_glyph_w-1:0]  r_data;

  // Each glyph is 16 rows of 8 bits, row 0 in the top byte, bit 7 leftmost.
  always_comb begin
    w_bits = '0;
    case (i_addr[7:4])
      4'd0:        w_bits = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
      4'd1:        w_bits = 128'h00001838781818181818187E00000000;
      4'd2:        w_bits = 128'h00007CC6060C183060C0C6FE00000000;
      4'd3:        w_bits = 128'h00007CC606063C060606C67C00000000;
      4'd4:        w_bits = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
      4'd5:        w_bits = 128'h0000FEC0C0C0FC060606C67C00000000;
      4'd6:        w_bits = 128'h00003860C0C0FCC6C6C6C67C00000000;
      4'd7:        w_bits = 128'h0000FEC606060C183030303000000000;
      4'd8:        w_bits = 128'h00007CC6C6C67CC6C6C6C67C00000000;
      4'd9:        w_bits = 128'h00007CC6C6C67E0606060C7800000000;
      GLYPH_COLON: w_bits = 128'h00000000181800000018180000000000;
      default:     w_bits = '0;
    endcase
  end

  assign w_shift = {4'd15 - i_addr[3:0], 3'b000};

  always_ff @(posedge clk) begin
    r_data <= w_bits[w_shift +: 8];
  end

  assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/draw_clock_digits.sv
`default_nettype none
// ----------------------------------------------------------------------------
// draw_clock_digits: HH:MM:SS x4-scaled glyph overlay with 3-cycle timing delay
// Rev 1.0
// ----------------------------------------------------------------------------
module draw_clock_digits
  import vga_pkg::*;
#(
  parameter int          XPOS      = 272,
  parameter int          YPOS      = 268,
  parameter logic [11:0] FG_COLOR  = 12'hFFF,
  parameter bit          COLON_BLK = 1'b1
) (
  input  logic               pclk,
  input  logic               rst_n,
  input  logic [10:0]        hcount_in,
  input  logic               hsync_in,
  input  logic               hblnk_in,
  input  logic [10:0]        vcount_in,
  input  logic               vsync_in,
  input  logic               vblnk_in,
  input  logic [c_rgb_w-1:0] rgb_in,
  input  logic [23:0]        time_bcd,
  output logic [10:0]        hcount_out,
  output logic               hsync_out,
  output logic               hblnk_out,
  output logic [10:0]        vcount_out,
  output logic               vsync_out,
  output logic               vblnk_out,
  output logic [c_rgb_w-1:0] rgb_out
);

  localparam logic [10:0] c_x0 = 11'(XPOS);
  localparam logic [10:0] c_x1 = 11'(XPOS + 256);
  localparam logic [10:0] c_y0 = 11'(YPOS);
  localparam logic [10:0] c_y1 = 11'(YPOS + 64);

  vga_timing_t        w_tim_in;
  vga_timing_t        r_s1_tim, r_s2_tim, r_s3_tim;
  logic [23:0]        r_time_q;
  logic [7:0]         w_rel_x;
  logic [5:0]         w_rel_y;
  logic               w_in_box;
  glyph_t             w_colon, w_code;
  glyph_t             r_s1_code;
  logic [3:0]         r_s1_row;
  logic [2:0]         r_s1_col, r_s2_col;
  logic               r_s1_in_box, r_s2_in_box;
  logic [c_rgb_w-1:0] r_s1_rgb, r_s2_rgb, r_s3_rgb;
  logic [7:0]         w_rom_byte;
  logic               w_pix;
  logic               w_unused;

  assign w_tim_in = {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in};
  // Only the low bits of the box offset are needed; wrap outside the box is gated by w_in_box.
  assign w_rel_x  = hcount_in[7:0] - c_x0[7:0];
  assign w_rel_y  = vcount_in[5:0] - c_y0[5:0];
  assign w_in_box = (hcount_in >= c_x0) && (hcount_in < c_x1) &&
                    (vcount_in >= c_y0) && (vcount_in < c_y1);
  assign w_unused = ^{w_rel_x[1:0], w_rel_y[1:0]};
  assign w_colon  = (COLON_BLK && r_time_q[0]) ? GLYPH_BLANK : GLYPH_COLON;

  always_comb begin
    w_code = GLYPH_BLANK;
    case (w_rel_x[7:5])
      3'd0:       w_code = bcd_to_glyph(r_time_q[23:20]);
      3'd1:       w_code = bcd_to_glyph(r_time_q[19:16]);
      3'd3:       w_code = bcd_to_glyph(r_time_q[15:12]);
      3'd4:       w_code = bcd_to_glyph(r_time_q[11:8]);
      3'd6:       w_code = bcd_to_glyph(r_time_q[7:4]);
      3'd7:       w_code = bcd_to_glyph(r_time_q[3:0]);
      default:    w_code = w_colon;
    endcase
  end

  // r_s1_tim.vblnk is last cycle's vblnk_in, so this fires once per frame.
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)
      r_time_q <= '0;
    else if (vblnk_in && !r_s1_tim.vblnk)
      r_time_q <= time_bcd;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_tim    <= '0;
      r_s1_code   <= '0;
      r_s1_row    <= '0;
      r_s1_col    <= '0;
      r_s1_in_box <= 1'b0;
      r_s1_rgb    <= '0;
      r_s2_tim    <= '0;
      r_s2_col    <= '0;
      r_s2_in_box <= 1'b0;
      r_s2_rgb    <= '0;
      r_s3_tim    <= '0;
      r_s3_rgb    <= '0;
    end else begin
      r_s1_tim    <= w_tim_in;
      r_s1_code   <= w_code;
      r_s1_row    <= w_rel_y[5:2];
      r_s1_col    <= w_rel_x[4:2];
      r_s1_in_box <= w_in_box;
      r_s1_rgb    <= rgb_in;
      r_s2_tim    <= r_s1_tim;
      r_s2_col    <= r_s1_col;
      r_s2_in_box <= r_s1_in_box;
      r_s2_rgb    <= r_s1_rgb;
      r_s3_tim    <= r_s2_tim;
      if (r_s2_tim.hblnk || r_s2_tim.vblnk)
        r_s3_rgb <= '0;
      else if (r_s2_in_box && w_pix)
        r_s3_rgb <= FG_COLOR;
      else
        r_s3_rgb <= r_s2_rgb;
    end
  end

  font_rom u_font_rom (
    .clk    (pclk),
    .i_addr ({r_s1_code, r_s1_row}),
    .o_data (w_rom_byte)
  );

  assign w_pix = w_rom_byte[3'd7 - r_s2_col];

  assign hcount_out = r_s3_tim.hcount;
  assign hsync_out  = r_s3_tim.hsync;
  assign hblnk_out  = r_s3_tim.hblnk;
  assign vcount_out = r_s3_tim.vcount;
  assign vsync_out  = r_s3_tim.vsync;
  assign vblnk_out  = r_s3_tim.vblnk;
  assign rgb_out    = r_s3_rgb;

endmodule
`default_nettype wire

// File: tb/tb_draw_clock_digits.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_draw_clock_digits: directed checks of reset, image, frame latch, colon,
// invalid BCD and blanking behaviour of the clock overlay
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_draw_clock_digits;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] hcount_in = '0, vcount_in = '0;
  logic        hsync_in = 1'b0, hblnk_in = 1'b0, vsync_in = 1'b0, vblnk_in = 1'b0;
  logic [11:0] rgb_in = '0;
  logic [23:0] time_bcd = '0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;

  draw_clock_digits dut (
    .pclk(pclk), .rst_n(rst_n),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .time_bcd(time_bcd),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 pclk = ~pclk;

  typedef struct packed {
    logic [10:0] h;
    logic        hs;
    logic        hb;
    logic [10:0] v;
    logic        vs;
    logic        vb;
    logic [11:0] rgb;
  } exp_t;

  localparam logic [127:0] FONT [0:10] = '{
    128'h00007CC6C6CEDEF6E6C6C67C00000000, 128'h00001838781818181818187E00000000,
    128'h00007CC6060C183060C0C6FE00000000, 128'h00007CC606063C060606C67C00000000,
    128'h00000C1C3C6CCCFE0C0C0C1E00000000, 128'h0000FEC0C0C0FC060606C67C00000000,
    128'h00003860C0C0FCC6C6C6C67C00000000, 128'h0000FEC606060C183030303000000000,
    128'h00007CC6C6C67CC6C6C6C67C00000000, 128'h00007CC6C6C67E0606060C7800000000,
    128'h00000000181800000018180000000000
  };

  exp_t        q[$];
  exp_t        e;
  bit          e_valid;
  logic [23:0] m_time;
  logic        m_prev_vb;
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic logic [11:0] model_rgb(input logic [10:0] h, input logic [10:0] v,
                                            input logic hb, input logic vb,
                                            input logic [11:0] rgb, input logic [23:0] tq);
    int rx, ry, slot, col, row;
    logic [3:0] nib, code;
    logic [127:0] g;
    if (hb || vb) return 12'h000;
    if (h < 272 || h >= 528 || v < 268 || v >= 332) return rgb;
    rx = int'(h) - 272;
    ry = int'(v) - 268;
    slot = rx / 32;
    col = (rx % 32) / 4;
    row = ry / 4;
    case (slot)
      0: nib = tq[23:20];
      1: nib = tq[19:16];
      3: nib = tq[15:12];
      4: nib = tq[11:8];
      6: nib = tq[7:4];
      7: nib = tq[3:0];
      default: nib = 4'd0;
    endcase
    if (slot == 2 || slot == 5) code = tq[0] ? 4'd15 : 4'd10;
    else code = (nib > 4'd9) ? 4'd15 : nib;
    if (code > 4'd10) return rgb;
    g = FONT[code];
    if (g[127 - row * 8 - col]) return 12'hFFF;
    return rgb;
  endfunction

  task automatic model_clear();
    q.delete();
    m_time = '0;
    m_prev_vb = 1'b0;
    e_valid = 1'b0;
  endtask

  // Drives one pixel, advances one clock; e then holds the expectation for the current outputs.
  task automatic tick(input logic [10:0] h, input logic [10:0] v, input logic hb,
                      input logic vb, input logic [11:0] rgb);
    exp_t x;
    hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = vb; rgb_in = rgb;
    hsync_in = (h >= 840 && h <= 967);
    vsync_in = (v >= 601 && v <= 604);
    x.h = h; x.hs = hsync_in; x.hb = hb; x.v = v; x.vs = vsync_in; x.vb = vb;
    x.rgb = model_rgb(h, v, hb, vb, rgb, m_time);
    if (vb && !m_prev_vb) m_time = time_bcd;
    m_prev_vb = vb;
    q.push_back(x);
    @(posedge pclk); #1;
    if (q.size() > 3) void'(q.pop_front());
    e_valid = (q.size() == 3);
    e = q[0];
  endtask

  task automatic new_frame(input logic [11:0] rgb);
    tick(11'd0, 11'd599, 1'b0, 1'b0, rgb);
    tick(11'd0, 11'd600, 1'b0, 1'b1, rgb);
  endtask

  task automatic test_reset();
    logic [10:0] h, v;
    rst_n = 1'b0;
    repeat (2) @(posedge pclk);
    #1 rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 6; i++) tick(11'(850 + i), 11'd602, 1'b0, 1'b0, 12'hABC);
    n_vec++;
    if ({hcount_out, hsync_out, vcount_out, vsync_out, rgb_out} !== {11'd853, 1'b1, 11'd602, 1'b1, 12'hABC}) begin
      n_bad++;
      $display("FAIL pre_reset: got h=%0d v=%0d rgb=%h, required h=853 v=602 rgb=abc", hcount_out, vcount_out, rgb_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} !== 25'd0) begin
      n_bad++;
      $display("FAIL reset_timing: got %h, required 0", {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out});
    end
    n_vec++;
    if (rgb_out !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_rgb: got %h, required 000", rgb_out);
    end
    @(posedge pclk); #1;
    n_vec++;
    if ({hcount_out, vcount_out, rgb_out} !== 34'd0) begin
      n_bad++;
      $display("FAIL reset_hold: got h=%0d v=%0d rgb=%h, required all 0", hcount_out, vcount_out, rgb_out);
    end
    rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 14; i++) begin
      h = 11'((1050 + i) % 1056);
      v = (i < 6) ? 11'd627 : 11'd0;
      tick(h, v, h >= 800, v >= 600, 12'(12'h123 + i));
      if (i < 2) begin
        n_vec++;
        if ({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out} !== 37'd0) begin
          n_bad++;
          $display("FAIL release_zero%0d: got h=%0d rgb=%h, required 0", i, hcount_out, rgb_out);
        end
      end else if (e_valid) begin
        n_vec++;
        if ({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out} !==
            {e.h, e.hs, e.hb, e.v, e.vs, e.vb, e.rgb}) begin
          n_bad++;
          $display("FAIL release_delay%0d: got h=%0d v=%0d rgb=%h, required h=%0d v=%0d rgb=%h",
                   i, hcount_out, vcount_out, rgb_out, e.h, e.v, e.rgb);
        end
      end
      if (i == 7) begin
        n_vec++;
        if ({hcount_out, vcount_out, hblnk_out, vblnk_out} !== {11'd1055, 11'd627, 1'b1, 1'b1}) begin
          n_bad++;
          $display("FAIL wrap_last: got h=%0d v=%0d, required h=1055 v=627", hcount_out, vcount_out);
        end
      end
      if (i == 8) begin
        n_vec++;
        if ({hcount_out, vcount_out, hblnk_out, vblnk_out, rgb_out} !== {11'd0, 11'd0, 1'b0, 1'b0, 12'h129}) begin
          n_bad++;
          $display("FAIL wrap_zero: got h=%0d v=%0d rgb=%h, required h=0 v=0 rgb=129", hcount_out, vcount_out, rgb_out);
        end
      end
    end
  endtask

  task automatic test_image();
    int err[0:8];
    int lit[0:7];
    int t_err, s, lit_slots;
    bit inb;
    for (int k = 0; k < 9; k++) err[k] = 0;
    for (int k = 0; k < 8; k++) lit[k] = 0;
    t_err = 0;
    time_bcd = 24'h123456;
    new_frame(12'h00F);
    for (int v = 267; v <= 332; v++) begin
      for (int h = 270; h <= 529; h++) begin
        tick(11'(h), 11'(v), 1'b0, 1'b0, 12'h00F);
        if (e_valid && !e.vb && e.v >= 267) begin
          inb = (e.h >= 272 && e.h < 528 && e.v >= 268 && e.v < 332);
          if (inb) begin
            s = (int'(e.h) - 272) / 32;
            if (rgb_out !== e.rgb) err[s]++;
            if (rgb_out === 12'hFFF) lit[s]++;
          end else if (rgb_out !== 12'h00F) err[8]++;
          if ({hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out} !==
              {e.h, e.hs, e.hb, e.v, e.vs, e.vb}) t_err++;
          if (e.h == 284 && e.v == 276) begin
            n_vec++;
            if (rgb_out !== 12'hFFF) begin
              n_bad++;
              $display("FAIL img_h10_pix: got %h, required fff", rgb_out);
            end
          end
          if (e.h == 372 && e.v == 276) begin
            n_vec++;
            if (rgb_out !== 12'hFFF) begin
              n_bad++;
              $display("FAIL img_m10_pix: got %h, required fff", rgb_out);
            end
          end
          if (e.h == 272 && e.v == 268) begin
            n_vec++;
            if (rgb_out !== 12'h00F) begin
              n_bad++;
              $display("FAIL img_corner: got %h, required 00f", rgb_out);
            end
          end
          if (e.h == 348 && e.v == 304) begin
            n_vec++;
            if (rgb_out !== 12'hFFF) begin
              n_bad++;
              $display("FAIL img_colon: got %h, required fff", rgb_out);
            end
          end
        end
      end
    end
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (err[k] !== 0) begin
        n_bad++;
        $display("FAIL img_slot%0d: %0d pixels differ from golden, required 0", k, err[k]);
      end
    end
    n_vec++;
    if (err[8] !== 0) begin
      n_bad++;
      $display("FAIL img_outside: %0d pixels not 00f, required 0", err[8]);
    end
    lit_slots = 0;
    for (int k = 0; k < 8; k++) if (lit[k] > 0) lit_slots++;
    n_vec++;
    if (lit_slots !== 8) begin
      n_bad++;
      $display("FAIL img_regions: got %0d lit glyph regions, required 8", lit_slots);
    end
    n_vec++;
    if (t_err !== 0) begin
      n_bad++;
      $display("FAIL img_timing: %0d delayed timing errors, required 0", t_err);
    end
  endtask

  task automatic test_frame_latch();
    for (int h = 270; h <= 530; h++) begin
      if (h == 400) time_bcd = 24'h000001;
      tick(11'(h), 11'd300, 1'b0, 1'b0, 12'h00F);
      if (e_valid && e.v == 300 && (e.h == 272 || e.h == 496)) begin
        n_vec++;
        if (rgb_out !== ((e.h == 496) ? 12'hFFF : 12'h00F)) begin
          n_bad++;
          $display("FAIL latch_old_%0d: got %h, required %h", e.h, rgb_out, (e.h == 496) ? 12'hFFF : 12'h00F);
        end
      end
    end
    new_frame(12'h00F);
    for (int h = 270; h <= 530; h++) begin
      tick(11'(h), 11'd300, 1'b0, 1'b0, 12'h00F);
      if (e_valid && e.v == 300 && (e.h == 272 || e.h == 496 || e.h == 508)) begin
        n_vec++;
        if (rgb_out !== ((e.h == 496) ? 12'h00F : 12'hFFF)) begin
          n_bad++;
          $display("FAIL latch_new_%0d: got %h, required %h", e.h, rgb_out, (e.h == 496) ? 12'h00F : 12'hFFF);
        end
      end
    end
  endtask

  task automatic test_colon();
    time_bcd = 24'h000004;
    new_frame(12'h0F0);
    for (int h = 340; h <= 450; h++) begin
      tick(11'(h), 11'd304, 1'b0, 1'b0, 12'h0F0);
      if (e_valid && e.v == 304 && (e.h == 348 || e.h == 444)) begin
        n_vec++;
        if (rgb_out !== 12'hFFF) begin
          n_bad++;
          $display("FAIL colon_lit_%0d: got %h, required fff", e.h, rgb_out);
        end
      end
    end
    time_bcd = 24'h000005;
    new_frame(12'h0F0);
    for (int h = 340; h <= 450; h++) begin
      tick(11'(h), 11'd304, 1'b0, 1'b0, 12'h0F0);
      if (e_valid && e.v == 304 && (e.h == 348 || e.h == 444)) begin
        n_vec++;
        if (rgb_out !== 12'h0F0) begin
          n_bad++;
          $display("FAIL colon_off_%0d: got %h, required 0f0", e.h, rgb_out);
        end
      end
    end
  endtask

  task automatic test_bad_bcd();
    int bad;
    bad = 0;
    time_bcd = 24'hAB0000;
    new_frame(12'h00F);
    for (int h = 270; h <= 400; h++) begin
      tick(11'(h), 11'd300, 1'b0, 1'b0, 12'h00F);
      if (e_valid && e.v == 300 && e.h >= 272 && e.h <= 335 && rgb_out !== 12'h00F) bad++;
      if (e_valid && e.v == 300 && e.h == 368) begin
        n_vec++;
        if (rgb_out !== 12'hFFF) begin
          n_bad++;
          $display("FAIL badbcd_m10: got %h, required fff", rgb_out);
        end
      end
    end
    n_vec++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL badbcd_hours: %0d lit pixels in hour slots, required 0", bad);
    end
  endtask

  task automatic test_blanking();
    int hb_err, vb_err;
    hb_err = 0;
    vb_err = 0;
    time_bcd = 24'h888888;
    for (int h = 797; h <= 1055; h++) begin
      tick(11'(h), 11'd300, h >= 800, 1'b0, 12'hFFF);
      if (e_valid && e.h >= 800 && rgb_out !== 12'h000) hb_err++;
      if (e_valid && (e.h == 800 || e.h == 900)) begin
        n_vec++;
        if (hsync_out !== (e.h == 900)) begin
          n_bad++;
          $display("FAIL hsync_%0d: got %b, required %b", e.h, hsync_out, e.h == 900);
        end
      end
    end
    for (int v = 600; v <= 627; v++) begin
      for (int h = 296; h <= 305; h++) begin
        tick(11'(h), 11'(v), 1'b0, 1'b1, 12'hFFF);
        if (e_valid && e.vb && rgb_out !== 12'h000) vb_err++;
      end
    end
    tick(11'd300, 11'd300, 1'b0, 1'b1, 12'hFFF);
    n_vec++;
    if (hb_err !== 0) begin
      n_bad++;
      $display("FAIL hblank_rgb: %0d nonzero pixels, required 0", hb_err);
    end
    n_vec++;
    if (vb_err !== 0) begin
      n_bad++;
      $display("FAIL vblank_rgb: %0d nonzero pixels, required 0", vb_err);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_image();
    test_frame_latch();
    test_colon();
    test_bad_bcd();
    test_blanking();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
